// File: rtl/ofs_plat_ccip_wr_rsp_gen.sv
// CCI-P channel-1 write response generator: assembles write packets, queues completions
// with a timestamp and answers them LATENCY cycles later. Define OFS_PLAT_CCIP_WR_RSP_REORDER_EN for a parked reorder slot.
module ofs_plat_ccip_wr_rsp_gen #(
  parameter int DEPTH              = 64,
  parameter int LATENCY            = 16,
  parameter int ALM_FULL_THRESHOLD = 8,
  parameter int MDATA_WIDTH        = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tx_valid,
  input  logic                   tx_is_fence,
  input  logic                   tx_sop,
  input  logic [1:0]             tx_cl_len,
  input  logic [MDATA_WIDTH-1:0] tx_mdata,
  output logic                   alm_full,
  output logic                   rsp_valid,
  output logic                   rsp_is_fence,
  output logic                   rsp_format,
  output logic [1:0]             rsp_cl_num,
  output logic [MDATA_WIDTH-1:0] rsp_mdata,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0]    LAT8     = 8'(LATENCY);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW+1:0] AF_LEVEL = (AW+2)'(DEPTH - ALM_FULL_THRESHOLD);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;
  typedef struct packed {
    logic                   fence;
    logic [1:0]             cl_num;
    logic [MDATA_WIDTH-1:0] mdata;
    logic [7:0]             ts;
  } entry_t;

  state_t state_q, state_d;
  logic [1:0] remaining_q, remaining_d, cl_len_q, cl_len_d;
  logic [MDATA_WIDTH-1:0] mdata_q, mdata_d;
  logic [7:0] ts_q, ts_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic alm_full_q, alm_full_d, err_q, err_d;
  logic rsp_valid_q, rsp_valid_d, rsp_is_fence_q, rsp_is_fence_d, rsp_format_q, rsp_format_d;
  logic [1:0] rsp_cl_num_q, rsp_cl_num_d;
  logic [MDATA_WIDTH-1:0] rsp_mdata_q, rsp_mdata_d;
  entry_t mem_q [DEPTH];

  logic proto_err, cpl, push, pop, drop, head_elig, emit, emit_fence;
  logic [1:0] emit_cl_num;
  logic [MDATA_WIDTH-1:0] emit_mdata;
  logic [7:0] elapsed;
  logic [AW+1:0] used;
  entry_t cpl_entry, head;

`ifdef OFS_PLAT_CCIP_WR_RSP_REORDER_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic park_valid_q, park_valid_d;
  logic [2:0] park_age_q, park_age_d;
  logic [1:0] park_cl_num_q, park_cl_num_d;
  logic [MDATA_WIDTH-1:0] park_mdata_q, park_mdata_d;
`endif

  // Packet assembler; illegal beats are dropped without touching assembler state.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    cl_len_d    = cl_len_q;
    mdata_d     = mdata_q;
    proto_err   = 1'b0;
    cpl         = 1'b0;
    cpl_entry   = '0;
    if (tx_valid) begin
      if (tx_is_fence) begin
        if (state_q == S_IDLE) begin
          cpl             = 1'b1;
          cpl_entry.fence = 1'b1;
          cpl_entry.mdata = tx_mdata;
          cpl_entry.ts    = ts_q;
        end else begin
          proto_err = 1'b1;
        end
      end else if (tx_sop) begin
        if (state_q == S_COLLECT) begin
          proto_err = 1'b1;
        end else if (tx_cl_len == 2'd0) begin
          cpl             = 1'b1;
          cpl_entry.mdata = tx_mdata;
          cpl_entry.ts    = ts_q;
        end else begin
          remaining_d = tx_cl_len;
          cl_len_d    = tx_cl_len;
          mdata_d     = tx_mdata;
          state_d     = S_COLLECT;
        end
      end else if (state_q == S_IDLE) begin
        proto_err = 1'b1;
      end else begin
        remaining_d = remaining_q - 2'd1;
        if (remaining_q == 2'd1) begin
          cpl              = 1'b1;
          cpl_entry.cl_num = cl_len_q;
          cpl_entry.mdata  = mdata_q;
          cpl_entry.ts     = ts_q;
          state_d          = S_IDLE;
        end
      end
    end
  end

  // Response selection, FIFO bookkeeping and registered outputs.
  always_comb begin
    ts_d      = ts_q + 8'd1;
    head      = mem_q[rd_ptr_q];
    elapsed   = ts_q - head.ts;
    head_elig = (count_q != '0) && (elapsed >= LAT8);
    pop         = 1'b0;
    emit        = 1'b0;
    emit_fence  = 1'b0;
    emit_cl_num = '0;
    emit_mdata  = '0;
`ifdef OFS_PLAT_CCIP_WR_RSP_REORDER_EN
    lfsr_d        = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    park_valid_d  = park_valid_q;
    park_cl_num_d = park_cl_num_q;
    park_mdata_d  = park_mdata_q;
    park_age_d    = (park_valid_q && park_age_q != 3'd7) ? park_age_q + 3'd1 : park_age_q;
    // A parked write must leave before any fence behind it can be answered.
    if (park_valid_q && (((count_q != '0) && head.fence) || park_age_q == 3'd7)) begin
      emit         = 1'b1;
      emit_cl_num  = park_cl_num_q;
      emit_mdata   = park_mdata_q;
      park_valid_d = 1'b0;
    end else if (head_elig) begin
      pop = 1'b1;
      if (!head.fence && !park_valid_q && lfsr_q[0]) begin
        park_valid_d  = 1'b1;
        park_cl_num_d = head.cl_num;
        park_mdata_d  = head.mdata;
        park_age_d    = '0;
      end else begin
        emit        = 1'b1;
        emit_fence  = head.fence;
        emit_cl_num = head.cl_num;
        emit_mdata  = head.mdata;
      end
    end else if (park_valid_q) begin
      emit         = 1'b1;
      emit_cl_num  = park_cl_num_q;
      emit_mdata   = park_mdata_q;
      park_valid_d = 1'b0;
    end
`else
    if (head_elig) begin
      pop         = 1'b1;
      emit        = 1'b1;
      emit_fence  = head.fence;
      emit_cl_num = head.cl_num;
      emit_mdata  = head.mdata;
    end
`endif
    // A same-cycle dequeue frees the slot before the full check.
    push     = cpl && ((count_q != FULL_CNT) || pop);
    drop     = cpl && !push;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
    used       = {1'b0, count_d} + (AW+2)'(state_d == S_COLLECT);
    alm_full_d = (used >= AF_LEVEL);
    err_d      = err_q | proto_err | drop;
    rsp_valid_d    = emit;
    rsp_is_fence_d = emit_fence;
    rsp_format_d   = emit;
    rsp_cl_num_d   = emit_cl_num;
    rsp_mdata_d    = emit_mdata;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cpl_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      remaining_q    <= '0;
      cl_len_q       <= '0;
      mdata_q        <= '0;
      ts_q           <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      alm_full_q     <= 1'b1;
      err_q          <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_is_fence_q <= 1'b0;
      rsp_format_q   <= 1'b0;
      rsp_cl_num_q   <= '0;
      rsp_mdata_q    <= '0;
`ifdef OFS_PLAT_CCIP_WR_RSP_REORDER_EN
      lfsr_q         <= 16'hACE1;
      park_valid_q   <= 1'b0;
      park_age_q     <= '0;
      park_cl_num_q  <= '0;
      park_mdata_q   <= '0;
`endif
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      cl_len_q       <= cl_len_d;
      mdata_q        <= mdata_d;
      ts_q           <= ts_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      alm_full_q     <= alm_full_d;
      err_q          <= err_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_is_fence_q <= rsp_is_fence_d;
      rsp_format_q   <= rsp_format_d;
      rsp_cl_num_q   <= rsp_cl_num_d;
      rsp_mdata_q    <= rsp_mdata_d;
`ifdef OFS_PLAT_CCIP_WR_RSP_REORDER_EN
      lfsr_q         <= lfsr_d;
      park_valid_q   <= park_valid_d;
      park_age_q     <= park_age_d;
      park_cl_num_q  <= park_cl_num_d;
      park_mdata_q   <= park_mdata_d;
`endif
    end
  end

  assign alm_full     = alm_full_q;
  assign err          = err_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_is_fence = rsp_is_fence_q;
  assign rsp_format   = rsp_format_q;
  assign rsp_cl_num   = rsp_cl_num_q;
  assign rsp_mdata    = rsp_mdata_q;
endmodule

// File: tb/tb_ofs_plat_ccip_wr_rsp_gen.sv
// Self-checking bench for ofs_plat_ccip_wr_rsp_gen: packet table plus hand-written corner
// sequences, with responses matched against a scoreboard queue.
module tb_ofs_plat_ccip_wr_rsp_gen;
  localparam int DEPTH   = 8;
  localparam int LATENCY = 16;
  localparam int THRESH  = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_valid = 1'b0, tx_is_fence = 1'b0, tx_sop = 1'b0;
  logic [1:0] tx_cl_len = '0;
  logic [15:0] tx_mdata = '0;
  logic alm_full, rsp_valid, rsp_is_fence, rsp_format, err;
  logic [1:0] rsp_cl_num;
  logic [15:0] rsp_mdata;

  ofs_plat_ccip_wr_rsp_gen #(
    .DEPTH(DEPTH), .LATENCY(LATENCY), .ALM_FULL_THRESHOLD(THRESH), .MDATA_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_is_fence(tx_is_fence),
    .tx_sop(tx_sop), .tx_cl_len(tx_cl_len), .tx_mdata(tx_mdata), .alm_full(alm_full),
    .rsp_valid(rsp_valid), .rsp_is_fence(rsp_is_fence), .rsp_format(rsp_format),
    .rsp_cl_num(rsp_cl_num), .rsp_mdata(rsp_mdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic fence; logic [1:0] cl; logic [15:0] mdata; int due; } exp_t;
  typedef struct { logic fence; logic [1:0] len; logic [15:0] mdata; logic exp_fence; logic [1:0] exp_cl; } vec_t;

  exp_t sb[$];
  int n_tests = 0, n_fail = 0, n_rsp = 0, n_pushed = 0, n_ooo = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Response monitor: every response must match an outstanding expectation.
  always @(negedge clk) begin
    int idx;
    int t;
    exp_t e;
    if (rsp_valid === 1'b1) begin
      n_rsp++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: actual mdata %0h, required no response", rsp_mdata);
      end else begin
        idx = 0;
`ifdef OFS_PLAT_CCIP_WR_RSP_REORDER_EN
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].mdata == rsp_mdata && sb[i].fence == rsp_is_fence) idx = i;
        if (idx > 0) n_ooo++;
        if (rsp_is_fence && idx >= 0) check("fence_after_older_writes", idx, 0);
`endif
        if (idx < 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_match: actual mdata %0h, required an outstanding entry", rsp_mdata);
        end else begin
          e = sb[idx];
          sb.delete(idx);
          check("rsp_is_fence", rsp_is_fence, e.fence);
          check("rsp_cl_num", rsp_cl_num, e.cl);
          check("rsp_mdata", rsp_mdata, e.mdata);
          check("rsp_format", rsp_format, 1);
          if (e.due != 0) begin
            t = cyc;
`ifdef OFS_PLAT_CCIP_WR_RSP_REORDER_EN
            if (t == e.due + 1) t = e.due;
`endif
            check("rsp_cycle", t, e.due);
          end
        end
      end
    end
  end

  task automatic drive(input logic f, input logic s, input logic [1:0] l, input logic [15:0] m);
    tx_valid = 1'b1; tx_is_fence = f; tx_sop = s; tx_cl_len = l; tx_mdata = m;
    @(posedge clk); #1;
    tx_valid = 1'b0; tx_is_fence = 1'b0; tx_sop = 1'b0; tx_cl_len = '0; tx_mdata = '0;
  endtask

  task automatic expect_rsp(input logic f, input logic [1:0] cl, input logic [15:0] m, input int due);
    exp_t e;
    e.fence = f; e.cl = cl; e.mdata = m; e.due = due;
    sb.push_back(e);
    n_pushed++;
  endtask

  task automatic send_pkt(input logic f, input logic [1:0] len, input logic [15:0] m);
    if (f) drive(1'b1, 1'b0, 2'd0, m);
    else begin
      drive(1'b0, 1'b1, len, m);
      for (int b = 0; b < int'(len); b++) drive(1'b0, 1'b0, 2'd0, 16'hDEAD);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      idle(1);
      n++;
    end
    check("drain_outstanding", sb.size(), 0);
    idle(LATENCY + 4);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: actual still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    int t0;
    vecs[0] = '{1'b0, 2'd3, 16'h0005, 1'b0, 2'd3};
    vecs[1] = '{1'b1, 2'd0, 16'h0006, 1'b1, 2'd0};
    vecs[2] = '{1'b0, 2'd1, 16'h0101, 1'b0, 2'd1};
    vecs[3] = '{1'b1, 2'd2, 16'h0A0A, 1'b1, 2'd0};
    vecs[4] = '{1'b0, 2'd2, 16'h0202, 1'b0, 2'd2};
    vecs[5] = '{1'b0, 2'd0, 16'hBEEF, 1'b0, 2'd0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_alm_full", alm_full, 1);
    check("reset_err", err, 0);
    check("reset_rsp_is_fence", rsp_is_fence, 0);
    check("reset_rsp_format", rsp_format, 0);
    check("reset_rsp_cl_num", rsp_cl_num, 0);
    check("reset_rsp_mdata", rsp_mdata, 0);
    reset = 1'b0;
    idle(1);
    check("alm_full_after_reset", alm_full, 0);
    idle(2);

    // Single-line write latency
    t0 = cyc;
    expect_rsp(1'b0, 2'd0, 16'h1234, t0 + 1 + LATENCY);
    send_pkt(1'b0, 2'd0, 16'h1234);
    drain(100);

    // Packet table, including write-then-fence ordering
    for (int i = 0; i < 6; i++) begin
      expect_rsp(vecs[i].exp_fence, vecs[i].exp_cl, vecs[i].mdata, 0);
      send_pkt(vecs[i].fence, vecs[i].len, vecs[i].mdata);
    end
    drain(200);
    check("rsp_count_table", n_rsp, n_pushed);
    check("err_clean", err, 0);

    // Fill to almost full and overflow
    for (int i = 1; i <= 9; i++) begin
      if (i <= DEPTH) expect_rsp(1'b0, 2'd0, 16'h3000 + 16'(i), 0);
      send_pkt(1'b0, 2'd0, 16'h3000 + 16'(i));
      if (i == 5) check("alm_full_after_5", alm_full, 0);
      if (i == 6) check("alm_full_after_6", alm_full, 1);
      if (i == 8) check("err_before_overflow", err, 0);
    end
    check("err_after_overflow", err, 1);
    drain(200);
    check("alm_full_drained", alm_full, 0);
    check("rsp_count_overflow", n_rsp, n_pushed);

    // Reset with queued entries and a packet in flight
    for (int i = 1; i <= 3; i++) begin
      expect_rsp(1'b0, 2'd0, 16'h4000 + 16'(i), 0);
      send_pkt(1'b0, 2'd0, 16'h4000 + 16'(i));
    end
    drive(1'b0, 1'b1, 2'd3, 16'h4444);
    drive(1'b0, 1'b0, 2'd0, 16'h0);
    reset = 1'b1;
    n_pushed -= sb.size();
    sb.delete();
    idle(2);
    check("mid_reset_err", err, 0);
    check("mid_reset_alm_full", alm_full, 1);
    check("mid_reset_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    idle(LATENCY + 24);
    expect_rsp(1'b0, 2'd0, 16'h0042, 0);
    send_pkt(1'b0, 2'd0, 16'h0042);
    drain(100);
    check("rsp_count_reset", n_rsp, n_pushed);

    // Protocol errors leave the in-progress packet intact
    check("err_before_proto", err, 0);
    drive(1'b0, 1'b0, 2'd0, 16'h0011);
    check("err_nonsop_idle", err, 1);
    expect_rsp(1'b0, 2'd1, 16'h0077, 0);
    drive(1'b0, 1'b1, 2'd1, 16'h0077);
    drive(1'b0, 1'b1, 2'd0, 16'h0099);
    drive(1'b1, 1'b0, 2'd0, 16'h0088);
    drive(1'b0, 1'b0, 2'd0, 16'h0000);
    drain(100);
    check("rsp_count_proto", n_rsp, n_pushed);
    check("err_sticky", err, 1);

    // Long stream of single-line writes closed by a fence
    for (int i = 0; i < 100; i++) begin
      expect_rsp(1'b0, 2'd0, 16'h5000 + 16'(i), 0);
      send_pkt(1'b0, 2'd0, 16'h5000 + 16'(i));
      idle(2);
    end
    expect_rsp(1'b1, 2'd0, 16'h5FFF, 0);
    send_pkt(1'b1, 2'd0, 16'h5FFF);
    drain(300);
    check("rsp_count_stream", n_rsp, n_pushed);
`ifdef OFS_PLAT_CCIP_WR_RSP_REORDER_EN
    check("reorder_observed", n_ooo > 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
